alu_operand_sequencer: RTL and testbench

On-chip stimulus driver and result collector for the 8-bit ALU user module. It drives the packed operand byte onto the ALU's io_in bus: A in bits [7:4], B in bits [3:0]. It waits a settle interval, samples io_out, and hands each {operand, result} pair to a downstream consumer over a valid/ready handshake. It sweeps a programmable vector range, so the silicon can self-exercise the ALU without external pin toggling.

---
 rtl/alu_operand_sequencer.sv | 102 ++++++++++
 tb/tb_alu_operand_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Sweeps packed ALU operand bytes START_VEC..END_VEC, holds each for SETTLE_CYCLES,
// then offers {operand, result} on a valid/ready port until the consumer accepts it.
module alu_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  START_VEC     = 8'h00,
  parameter logic [7:0]  END_VEC       = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  alu_in,
  input  logic [7:0]  alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [7:0]  alu_in_q;
  logic        res_valid_q;
  logic [15:0] res_data_q;
  logic        busy_q;
  logic        done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      alu_in_q    <= 8'h00;
      res_valid_q <= 1'b0;
      res_data_q  <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // abort outranks both counter expiry and a same-cycle handshake
      if (abort && (state_q != IDLE)) begin
        state_q     <= IDLE;
        res_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              alu_in_q <= START_VEC;
              cnt_q    <= CNT_RELOAD;
              busy_q   <= 1'b1;
              state_q  <= SETTLE;
            end
          end
          SETTLE: begin
            if (cnt_q != 4'd0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              res_data_q  <= {alu_in_q, alu_out};
              res_valid_q <= 1'b1;
              state_q     <= VALID;
            end
          end
          VALID: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              if (alu_in_q == END_VEC) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                alu_in_q <= alu_in_q + 8'd1;
                cnt_q    <= CNT_RELOAD;
                state_q  <= SETTLE;
              end
            end
          end
          default: begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign alu_in    = alu_in_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Three sequencers (full sweep, single vector, short sweep with 1-cycle settle) share
// control inputs and are checked every cycle against an event-level model plus literal pins.
module tb_alu_operand_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        res_ready;

  logic [7:0]  alu_in0, alu_in1, alu_in2;
  logic [7:0]  alu_out0, alu_out1, alu_out2;
  logic        res_valid0, res_valid1, res_valid2;
  logic [15:0] res_data0, res_data1, res_data2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  int cmp_n = 0;
  int err_n = 0;

  function automatic logic [7:0] alu(input logic [7:0] v);
    return {4'h0, v[7:4]} + {4'h0, v[3:0]};
  endfunction

  assign alu_out0 = alu(alu_in0);
  assign alu_out1 = alu(alu_in1);
  assign alu_out2 = alu(alu_in2);

  alu_operand_sequencer #(.SETTLE_CYCLES(2), .START_VEC(8'h00), .END_VEC(8'hFF)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alu_in(alu_in0),
    .alu_out(alu_out0), .res_valid(res_valid0), .res_ready(res_ready),
    .res_data(res_data0), .busy(busy0), .done(done0));

  alu_operand_sequencer #(.SETTLE_CYCLES(2), .START_VEC(8'h12), .END_VEC(8'h12)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alu_in(alu_in1),
    .alu_out(alu_out1), .res_valid(res_valid1), .res_ready(res_ready),
    .res_data(res_data1), .busy(busy1), .done(done1));

  alu_operand_sequencer #(.SETTLE_CYCLES(1), .START_VEC(8'hF0), .END_VEC(8'hFF)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .alu_in(alu_in2),
    .alu_out(alu_out2), .res_valid(res_valid2), .res_ready(res_ready),
    .res_data(res_data2), .busy(busy2), .done(done2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: "age" counts edges since the current vector was driven; the result
  // becomes visible once age reaches the settle interval.
  typedef struct packed {
    logic        busy;
    logic        valid;
    logic        done;
    logic [7:0]  vec;
    logic [7:0]  age;
    logic [15:0] data;
  } mdl_t;

  function automatic mdl_t mdl_step(input mdl_t m, input int s, input logic [7:0] sv,
                                    input logic [7:0] ev, input logic rn, input logic st,
                                    input logic ab, input logic rdy);
    mdl_t n;
    n = m;
    n.done = 1'b0;
    if (!rn) begin
      n = '0;
    end else if (!m.busy) begin
      if (st) begin
        n.busy = 1'b1;
        n.vec  = sv;
        n.age  = 8'd0;
      end
    end else if (ab) begin
      n.busy  = 1'b0;
      n.valid = 1'b0;
    end else if (m.valid) begin
      if (rdy) begin
        n.valid = 1'b0;
        if (m.vec == ev) begin
          n.busy = 1'b0;
          n.done = 1'b1;
        end else begin
          n.vec = m.vec + 8'd1;
          n.age = 8'd0;
        end
      end
    end else begin
      n.age = m.age + 8'd1;
      if (n.age == 8'(s)) begin
        n.valid = 1'b1;
        n.data  = {m.vec, alu(m.vec)};
      end
    end
    return n;
  endfunction

  mdl_t m0 = '0, m1 = '0, m2 = '0;
  logic mdl_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) mdl_ok <= 1'b1;
    m0 <= mdl_step(m0, 2, 8'h00, 8'hFF, rst_n, start, abort, res_ready);
    m1 <= mdl_step(m1, 2, 8'h12, 8'h12, rst_n, start, abort, res_ready);
    m2 <= mdl_step(m2, 1, 8'hF0, 8'hFF, rst_n, start, abort, res_ready);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input logic [7:0] ai,
                         input logic rv, input logic [15:0] rd, input logic b, input logic d);
    chk({tag, ".alu_in"},    32'(ai), 32'(m.vec));
    chk({tag, ".res_valid"}, 32'(rv), 32'(m.valid));
    chk({tag, ".res_data"},  32'(rd), 32'(m.data));
    chk({tag, ".busy"},      32'(b),  32'(m.busy));
    chk({tag, ".done"},      32'(d),  32'(m.done));
  endtask

  always @(negedge clk) begin
    if (mdl_ok) begin
      cmp_dut("u0", m0, alu_in0, res_valid0, res_data0, busy0, done0);
      cmp_dut("u1", m1, alu_in1, res_valid1, res_data1, busy1, done1);
      cmp_dut("u2", m2, alu_in2, res_valid2, res_data2, busy2, done2);
    end
  end

  // Accepted results from u0: a handshake happens at the next edge when these hold.
  logic [15:0] acc_q[$];
  int          done0_n = 0;

  always @(negedge clk) begin
    if (rst_n && !abort && busy0 && res_valid0 && res_ready) acc_q.push_back(res_data0);
    if (done0) done0_n++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start = 1'b1; abort = 1'b0; res_ready = 1'b1;
    repeat (3) step();
    chk("rst_alu_in",    32'(alu_in0),    32'h00);
    chk("rst_res_data",  32'(res_data0),  32'h0000);
    chk("rst_res_valid", 32'(res_valid0), 32'h0);
    chk("rst_busy",      32'(busy0),      32'h0);
    rst_n = 1'b1; start = 1'b0;
    step();
    chk("start_in_reset_ignored", 32'(busy0), 32'h0);

    // single-vector sweep on u1, full sweep on u0 starts on the same edge
    acc_q.delete(); done0_n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("u1_alu_in_after_start", 32'(alu_in1), 32'h12);
    chk("u1_busy_after_start",   32'(busy1),   32'h1);
    step();
    chk("u1_valid_not_yet", 32'(res_valid1), 32'h0);
    step();
    chk("u1_valid_rise", 32'(res_valid1), 32'h1);
    chk("u1_res_data",   32'(res_data1),  32'h1203);
    step();
    chk("u1_done_pulse", 32'(done1), 32'h1);
    chk("u1_busy_clear", 32'(busy1), 32'h0);
    step();
    chk("u1_done_single", 32'(done1), 32'h0);

    // backpressure on vector 22
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (alu_in0 == 8'h22 && res_valid0) begin found = 1'b1; break; end
      step();
    end
    chk("reach_vec22", 32'(found), 32'h1);
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid_hold", 32'(res_valid0), 32'h1);
      chk("bp_data_hold",  32'(res_data0),  32'h2204);
      chk("bp_alu_in",     32'(alu_in0),    32'h22);
    end
    res_ready = 1'b1;
    step();
    chk("bp_advance", 32'(alu_in0), 32'h23);

    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy0) begin found = 1'b1; break; end
      step();
    end
    chk("sweep_finished", 32'(found), 32'h1);
    repeat (4) step();
    chk("sweep_count",      32'(acc_q.size()), 32'd256);
    chk("sweep_done_count", 32'(done0_n),      32'd1);
    chk("sweep_alu_in_end", 32'(alu_in0),      32'hFF);
    if (acc_q.size() == 256) begin
      chk("sweep_first", 32'(acc_q[0]),   32'h0000);
      chk("sweep_22",    32'(acc_q[34]),  32'h2204);
      chk("sweep_last",  32'(acc_q[255]), 32'hFF1E);
      for (int i = 0; i < 256; i++)
        chk("sweep_entry", 32'(acc_q[i]), 32'({i[7:0], alu(i[7:0])}));
    end

    // abort during settle on vector 05
    done0_n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (alu_in0 == 8'h05 && busy0 && !res_valid0) begin found = 1'b1; break; end
      step();
    end
    chk("reach_vec05", 32'(found), 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy",  32'(busy0),      32'h0);
    chk("abort_valid", 32'(res_valid0), 32'h0);
    chk("abort_done",  32'(done0),      32'h0);
    step();
    chk("abort_no_done", 32'(done0_n), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_vec", 32'(alu_in0), 32'h00);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // reset while in VALID
    res_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("pre_rst_valid", 32'(res_valid2), 32'h1);
    rst_n = 1'b0; start = 1'b1;
    step();
    chk("mid_rst_alu_in",   32'(alu_in2),    32'h00);
    chk("mid_rst_res_data", 32'(res_data2),  32'h0000);
    chk("mid_rst_valid",    32'(res_valid0), 32'h0);
    chk("mid_rst_busy",     32'(busy0),      32'h0);
    rst_n = 1'b1; start = 1'b0;
    step();
    chk("post_rst_idle", 32'(busy0), 32'h0);

    // start while busy, then start+abort+ready on one edge
    start = 1'b1;
    step();
    chk("s1_alu_in",     32'(alu_in2),    32'hF0);
    chk("s1_valid_wait", 32'(res_valid2), 32'h0);
    step();
    start = 1'b0;
    chk("s1_valid_rise", 32'(res_valid2), 32'h1);
    chk("s1_res_data",   32'(res_data2),  32'hF00F);
    chk("busy_start_ignored", 32'(alu_in0), 32'h00);
    step();
    chk("u0_in_valid", 32'(res_valid0), 32'h1);
    start = 1'b1; abort = 1'b1; res_ready = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("combo_busy",   32'(busy0),   32'h0);
    chk("combo_done",   32'(done0),   32'h0);
    chk("combo_alu_in", 32'(alu_in0), 32'h00);
    chk("combo_s1_in",  32'(alu_in2), 32'hF0);
    chk("combo_s1_bsy", 32'(busy2),   32'h0);

    // randomized phase, model checks every cycle
    for (int i = 0; i < 4000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      res_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
